// File: rtl/prx_reg_bank_pkg.sv
// Shared address map, read FSM state type and table-window decode helper
// for the packet-receiver configuration register bank.
package prx_reg_bank_pkg;

  localparam logic [7:0] RT_KEY_BASE = 8'h00;
  localparam logic [7:0] RT_MSK_BASE = 8'h10;
  localparam logic [7:0] RT_RTE_BASE = 8'h20;
  localparam logic [7:0] CNT0_ADDR   = 8'h40;
  localparam logic [7:0] CNT1_ADDR   = 8'h41;

  typedef enum logic {
    RD_IDLE = 1'b0,
    RD_RESP = 1'b1
  } rd_state_t;

  // A table window is 16 addresses wide; entries at or above num are unmapped.
  function automatic logic table_hit(input logic [7:0] addr, input logic [7:0] base,
                                     input int num);
    return ((addr & 8'hF0) == base) && (int'(addr[3:0]) < num);
  endfunction

endpackage

// File: rtl/prx_reg_bank_sat_counter.sv
// 32-bit saturating up-counter with a parallel load that takes priority
// over the increment.
module sat_counter (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic [31:0] load_val,
  input  logic        inc,
  output logic [31:0] count
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (inc && (count != 32'hFFFF_FFFF)) begin
      count <= count + 32'd1;
    end
  end

endmodule

// File: rtl/prx_reg_bank.sv
// Configuration register bank: routing table, two packet counters and a
// single-outstanding host read port.
//
// state   | meaning
// RD_IDLE | ready for a read request (rd_rdy_out=1)
// RD_RESP | response held on rd_data_out/rd_err_out until accepted
module prx_reg_bank
  import prx_reg_bank_pkg::*;
#(
  parameter int NUM_RT     = 16,
  parameter int ROUTE_BITS = 3
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [7:0]                   prx_addr_in,
  input  logic [31:0]                  prx_data_in,
  input  logic                         prx_vld_in,
  input  logic [1:0]                   prx_cnt_in,
  input  logic [7:0]                   rd_addr_in,
  input  logic                         rd_vld_in,
  output logic                         rd_rdy_out,
  output logic [31:0]                  rd_data_out,
  output logic                         rd_err_out,
  output logic                         rd_resp_vld_out,
  input  logic                         rd_resp_rdy_in,
  output logic [NUM_RT*32-1:0]         rt_key_out,
  output logic [NUM_RT*32-1:0]         rt_mask_out,
  output logic [NUM_RT*ROUTE_BITS-1:0] rt_route_out
);

  localparam int IDX_W = (NUM_RT > 1) ? $clog2(NUM_RT) : 1;

  logic [31:0]           key_q   [NUM_RT];
  logic [31:0]           mask_q  [NUM_RT];
  logic [ROUTE_BITS-1:0] route_q [NUM_RT];
  logic [31:0]           cnt0, cnt1;

  logic [IDX_W-1:0] wr_idx, rd_idx;
  logic             wr_key, wr_msk, wr_rte, wr_cnt0, wr_cnt1;
  logic [31:0]      rd_mux_data;
  logic             rd_mux_err;
  rd_state_t        rd_state;

  assign wr_idx  = prx_addr_in[IDX_W-1:0];
  assign rd_idx  = rd_addr_in[IDX_W-1:0];
  assign wr_key  = prx_vld_in && table_hit(prx_addr_in, RT_KEY_BASE, NUM_RT);
  assign wr_msk  = prx_vld_in && table_hit(prx_addr_in, RT_MSK_BASE, NUM_RT);
  assign wr_rte  = prx_vld_in && table_hit(prx_addr_in, RT_RTE_BASE, NUM_RT);
  assign wr_cnt0 = prx_vld_in && (prx_addr_in == CNT0_ADDR);
  assign wr_cnt1 = prx_vld_in && (prx_addr_in == CNT1_ADDR);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_RT; i++) begin
        key_q[i]   <= '0;
        mask_q[i]  <= '0;
        route_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_RT; i++) begin
        if (wr_key && (wr_idx == IDX_W'(i))) key_q[i] <= prx_data_in;
        if (wr_msk && (wr_idx == IDX_W'(i))) mask_q[i] <= prx_data_in;
        if (wr_rte && (wr_idx == IDX_W'(i))) route_q[i] <= prx_data_in[ROUTE_BITS-1:0];
      end
    end
  end

  sat_counter u_cnt0 (
    .clk      (clk),
    .reset    (reset),
    .load     (wr_cnt0),
    .load_val (prx_data_in),
    .inc      (prx_cnt_in[0]),
    .count    (cnt0)
  );

  sat_counter u_cnt1 (
    .clk      (clk),
    .reset    (reset),
    .load     (wr_cnt1),
    .load_val (prx_data_in),
    .inc      (prx_cnt_in[1]),
    .count    (cnt1)
  );

  for (genvar g = 0; g < NUM_RT; g++) begin : g_flat
    assign rt_key_out[32*g +: 32]                 = key_q[g];
    assign rt_mask_out[32*g +: 32]                = mask_q[g];
    assign rt_route_out[ROUTE_BITS*g +: ROUTE_BITS] = route_q[g];
  end

  // Mux reads pre-edge register contents, so a same-cycle write is not seen.
  always_comb begin
    rd_mux_data = '0;
    rd_mux_err  = 1'b1;
    if (table_hit(rd_addr_in, RT_KEY_BASE, NUM_RT)) begin
      rd_mux_data = key_q[rd_idx];
      rd_mux_err  = 1'b0;
    end else if (table_hit(rd_addr_in, RT_MSK_BASE, NUM_RT)) begin
      rd_mux_data = mask_q[rd_idx];
      rd_mux_err  = 1'b0;
    end else if (table_hit(rd_addr_in, RT_RTE_BASE, NUM_RT)) begin
      rd_mux_data = 32'(route_q[rd_idx]);
      rd_mux_err  = 1'b0;
    end else if (rd_addr_in == CNT0_ADDR) begin
      rd_mux_data = cnt0;
      rd_mux_err  = 1'b0;
    end else if (rd_addr_in == CNT1_ADDR) begin
      rd_mux_data = cnt1;
      rd_mux_err  = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_state        <= RD_IDLE;
      rd_rdy_out      <= 1'b1;
      rd_resp_vld_out <= 1'b0;
      rd_data_out     <= '0;
      rd_err_out      <= 1'b0;
    end else begin
      case (rd_state)
        RD_IDLE: begin
          if (rd_vld_in) begin
            rd_data_out     <= rd_mux_data;
            rd_err_out      <= rd_mux_err;
            rd_resp_vld_out <= 1'b1;
            rd_rdy_out      <= 1'b0;
            rd_state        <= RD_RESP;
          end
        end
        RD_RESP: begin
          if (rd_resp_rdy_in) begin
            rd_resp_vld_out <= 1'b0;
            rd_rdy_out      <= 1'b1;
            rd_state        <= RD_IDLE;
          end
        end
        default: begin
          rd_state        <= RD_IDLE;
          rd_rdy_out      <= 1'b1;
          rd_resp_vld_out <= 1'b0;
        end
      endcase
    end
  end

endmodule
